// File: rtl/regfile_scoreboard.sv
// -----------------------------------------------------------------------------
// regfile_scoreboard
//
// A 2-read/1-write register file with one pending (scoreboard) bit per
// register. It sits between decode/issue and writeback:
//   - issue reserves a destination (sets its pending bit),
//   - writeback stores data and clears the pending bit,
//   - the read ports return operand data and whether that operand is ready.
//
// Parameters
//   DATA_WIDTH  bits per register
//   DEPTH       number of registers (power of 2, >= 2)
//   ADDR_WIDTH  address width, 2**ADDR_WIDTH >= DEPTH
//   ZERO_REG    1: register 0 is hard-wired zero (never written or pending)
//
// Ports
//   clk          clock, all state updates on the rising edge
//   reset        synchronous, active-high; clears data, pending bits, count
//   wr_en        writeback strobe
//   wr_addr      writeback destination
//   wr_data      writeback data
//   rsv_en       reserve strobe (issued instruction with a destination)
//   rsv_addr     register to mark pending
//   rd_addr_1/2  read addresses
//   rd_data_1/2  combinational read data
//   rd_valid_1/2 1 = addressed register is not pending
//   pending_cnt  registered count of pending registers
//
// Build option
//   REGFILE_BYPASS_EN  when defined, a read of the register being written in
//                      the same cycle returns wr_data directly. Without it,
//                      new data becomes visible the cycle after the write.
//
// Addresses at or above DEPTH are out of range: writes and reserves to them
// are dropped, reads return 0 with valid=1.
// -----------------------------------------------------------------------------
module regfile_scoreboard #(
    parameter int DATA_WIDTH = 64,
    parameter int DEPTH      = 16,
    parameter int ADDR_WIDTH = 5,
    parameter int ZERO_REG   = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rsv_en,
    input  logic [ADDR_WIDTH-1:0] rsv_addr,
    input  logic [ADDR_WIDTH-1:0] rd_addr_1,
    input  logic [ADDR_WIDTH-1:0] rd_addr_2,
    output logic [DATA_WIDTH-1:0] rd_data_1,
    output logic [DATA_WIDTH-1:0] rd_data_2,
    output logic                  rd_valid_1,
    output logic                  rd_valid_2,
    output logic [ADDR_WIDTH:0]   pending_cnt
);

    localparam int                IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Carries one extra bit so DEPTH == 2**ADDR_WIDTH still compares correctly.
    localparam logic [ADDR_WIDTH:0] DEPTH_W = (ADDR_WIDTH+1)'(DEPTH);

    typedef struct packed {
        logic                  valid;
        logic [DATA_WIDTH-1:0] data;
    } rd_t;

    logic [DATA_WIDTH-1:0] regs_q [DEPTH];
    logic [DEPTH-1:0]      pending_q, pending_d;
    logic [ADDR_WIDTH:0]   cnt_q, cnt_d;

    logic                  wr_ok, rsv_ok;
    logic [IDX_W-1:0]      wr_idx, rsv_idx;
    rd_t                   rd_1, rd_2;

    // An address is writable/reservable if it is in range and is not the
    // hard-wired zero register.
    function automatic logic addr_ok(input logic [ADDR_WIDTH-1:0] a);
        logic in_range;
        logic is_zero;
        in_range = ({1'b0, a} < DEPTH_W);
        is_zero  = (ZERO_REG != 0) && (a == '0);
        return in_range && !is_zero;
    endfunction

    assign wr_ok   = wr_en  && addr_ok(wr_addr);
    assign rsv_ok  = rsv_en && addr_ok(rsv_addr);
    assign wr_idx  = wr_addr[IDX_W-1:0];
    assign rsv_idx = rsv_addr[IDX_W-1:0];

    // Next pending vector and its popcount. The reserve is applied after the
    // writeback so a same-address write+reserve leaves the register pending:
    // the newly issued producer owns it.
    always_comb begin
        // NOTE: every variable gets a default before any conditional update,
        // otherwise an unassigned path would infer a latch.
        pending_d = pending_q;
        if (wr_ok)  pending_d[wr_idx]  = 1'b0;
        if (rsv_ok) pending_d[rsv_idx] = 1'b1;

        cnt_d = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_d = cnt_d + (ADDR_WIDTH+1)'(pending_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            // NOTE: the data array is cleared on reset because reads must
            // return 0 afterwards; this rules out mapping it onto a RAM macro.
            for (int i = 0; i < DEPTH; i++) begin
                regs_q[i] <= '0;
            end
            pending_q <= '0;
            cnt_q     <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // register samples pre-edge values regardless of statement order.
            if (wr_ok) regs_q[wr_idx] <= wr_data;
            pending_q <= pending_d;
            cnt_q     <= cnt_d;
        end
    end

    // One read port: out-of-range and zero-register reads give 0/valid.
    function automatic rd_t read_port(input logic [ADDR_WIDTH-1:0] a);
        rd_t r;
        r.valid = 1'b1;
        r.data  = '0;
        if (addr_ok(a)) begin
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (wr_addr == a)) begin
                r.data  = wr_data;
                r.valid = !(rsv_ok && (rsv_addr == a));
            end else begin
                r.data  = regs_q[a[IDX_W-1:0]];
                r.valid = !pending_q[a[IDX_W-1:0]];
            end
`else
            r.data  = regs_q[a[IDX_W-1:0]];
            r.valid = !pending_q[a[IDX_W-1:0]];
`endif
        end
        return r;
    endfunction

    always_comb begin
        rd_1 = read_port(rd_addr_1);
        rd_2 = read_port(rd_addr_2);
    end

    assign rd_data_1   = rd_1.data;
    assign rd_valid_1  = rd_1.valid;
    assign rd_data_2   = rd_2.data;
    assign rd_valid_2  = rd_2.valid;
    assign pending_cnt = cnt_q;

endmodule
